// File: rtl/button_debouncer.sv
// Debounces one raw asynchronous button into a registered level plus one-cycle rise/fall pulses.
// Latency N_SYNC+1+DEBOUNCE_CYCLES edges from a stable input change; no backpressure.
module button_debouncer #(
  parameter int N_SYNC          = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_RISING  = 2'd1,
    S_HIGH    = 2'd2,
    S_FALLING = 2'd3
  } state_t;

  logic [N_SYNC-1:0] r_sync;
  logic              w_s;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_level;
  logic              w_level_nxt;
  logic              r_rise;
  logic              w_rise_nxt;
  logic              r_fall;
  logic              w_fall_nxt;
  logic              r_busy;
  logic              w_busy_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N_SYNC-2:0], btn_raw};
    end
  end

  assign w_s = r_sync[N_SYNC-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // A sample disagreeing with the pending change drops back to the originating stable state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      S_LOW: begin
        if (w_s) begin
          w_state_nxt = S_RISING;
          w_cnt_nxt   = '0;
        end
      end
      S_RISING: begin
        if (!w_s) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!w_s) begin
          w_state_nxt = S_FALLING;
          w_cnt_nxt   = '0;
        end
      end
      S_FALLING: begin
        if (w_s) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_RISING) || (w_state_nxt == S_FALLING);
  end

  assign btn_level = r_level;
  assign btn_rise  = r_rise;
  assign btn_fall  = r_fall;
  assign busy      = r_busy;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: default debouncer plus a DEBOUNCE_CYCLES=1 instance sharing the same stimulus.
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic btn_raw;

  logic level0, rise0, fall0, busy0;
  logic level1, rise1, fall1, busy1;
  logic [3:0] obs0, obs1;

  int n_assert;
  int n_fail;
  int rise_cnt;

  assign obs0 = {level0, rise0, fall0, busy0};
  assign obs1 = {level1, rise1, fall1, busy1};

  button_debouncer #(.N_SYNC(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (level0),
    .btn_rise  (rise0),
    .btn_fall  (fall0),
    .busy      (busy0)
  );

  button_debouncer #(.N_SYNC(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (level1),
    .btn_rise  (rise1),
    .btn_fall  (fall1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vectors are packed {level, rise, fall, busy}.
  task automatic chk(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rise_cnt = 0;
    rst      = 1'b0;
    btn_raw  = 1'b1;

    // Async reset mid-cycle with the button high.
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    chk("async_rst", 0, obs0, 4'b0000);
    chk("async_rst_d1", 0, obs1, 4'b0000);
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk("rst_hold", k, obs0, 4'b0000);
    end

    // Release with the button low: nothing may move.
    btn_raw = 1'b0;
    #2 rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("idle_low", k, obs0, 4'b0000);
    end

    // Bounce 1,1,0,1,1 then 0 held: rejected, busy ends low.
    for (int k = 1; k <= 12; k++) begin
      btn_raw = (k == 1 || k == 2 || k == 4 || k == 5);
      tick();
      chk("bounce", k, obs0, {3'b000, (k == 3 || k == 4 || k == 6 || k == 7)});
    end

    // Clean press.
    btn_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("press", k, obs0, {(k >= 7), (k == 7), 1'b0, (k >= 3 && k <= 6)});
      chk("press_d1", k, obs1, {(k >= 4), (k == 4), 1'b0, (k == 3)});
    end

    // Release from high.
    btn_raw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("release", k, obs0, {(k < 7), 1'b0, (k == 7), (k >= 3 && k <= 6)});
      chk("release_d1", k, obs1, {(k < 4), 1'b0, (k == 4), (k == 3)});
    end

    // Press, then reset lands while counting.
    btn_raw = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("pre_rst_count", k, obs0, {3'b000, (k >= 3)});
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_count_rst", 0, obs0, 4'b0000);
    tick();
    chk("mid_count_rst_edge", 0, obs0, 4'b0000);
    chk("mid_count_rst_edge_d1", 0, obs1, 4'b0000);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rise0) rise_cnt++;
      chk("post_rst_press", k, obs0, {(k >= 7), (k == 7), 1'b0, (k >= 3 && k <= 6)});
      chk("post_rst_press_d1", k, obs1, {(k >= 4), (k == 4), 1'b0, (k == 3)});
    end
    chk("post_rst_rise_count", 0, 4'(rise_cnt), 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
